// File: rtl/wb_arbiter.sv
// Write-back arbiter: fixed-priority ALU path, FIFO-buffered memory path, pending-load scoreboard.
// Optional WB_BYPASS_EN lets a memory result skip an empty FIFO when the ALU is idle.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_issue,
  input  logic [4:0]  mem_issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] writeBackData
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [36:0]   buf_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   pending_q, pending_d;

  logic        full, empty, mem_take, alu_win, byp, pop, push, clr_vld;
  logic [4:0]  clr_rd;
  logic [36:0] head;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign mem_ready = !full;
  assign mem_take  = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
`ifdef WB_BYPASS_EN
  assign byp = !alu_valid && empty && mem_take;
`else
  assign byp = 1'b0;
`endif
  assign pop  = !alu_win && !empty;
  assign push = mem_take && !byp;
  assign head = buf_q[rptr_q];

  always_comb begin
    we_d    = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    clr_vld = 1'b0;
    clr_rd  = head[36:32];
    if (alu_win) begin
      we_d   = 1'b1;
      rd_d   = alu_rd;
      data_d = alu_data;
    end else if (pop) begin
      we_d    = 1'b1;
      rd_d    = head[36:32];
      data_d  = head[31:0];
      clr_vld = 1'b1;
    end else if (byp) begin
      we_d    = 1'b1;
      rd_d    = mem_rd;
      data_d  = mem_data;
      clr_vld = 1'b1;
      clr_rd  = mem_rd;
    end
  end

  // Clear first so a same-cycle re-issue of the same register keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_vld) pending_d[clr_rd] = 1'b0;
    if (mem_issue && (mem_issue_rd != 5'd0)) pending_d[mem_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= {mem_rd, mem_data};
  end

  assign rs1_busy      = pending_q[rs1];
  assign rs2_busy      = pending_q[rs2];
  assign RegWrite      = we_q;
  assign rd            = rd_q;
  assign writeBackData = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, directed corner sequences, randomized run against a queue model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, mem_issue;
  logic [4:0]  alu_rd, mem_rd, mem_issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        mem_ready, rs1_busy, rs2_busy, RegWrite;
  logic [4:0]  o_rd;
  logic [31:0] writeBackData;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_issue(mem_issue), .mem_issue_rd(mem_issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .RegWrite(RegWrite), .rd(o_rd), .writeBackData(writeBackData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        mi;  logic [4:0] mird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        ewe; logic [4:0] erd; logic [31:0] ed;
    logic        erdy; logic eb1; logic eb2;
  } vec_t;

  vec_t tbl [8];

  // Reference model: FIFO as a queue, pending as a plain bit array.
  logic [36:0] mq [$];
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    mem_issue = 0; mem_issue_rd = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    #12;
    rst_n = 1;
    mq.delete();
    m_we = 0; m_rd = 0; m_data = 0; m_pend = 0;
    tick();
  endtask

  task automatic model_step();
    bit rdy, take, byp, clr;
    logic [4:0] crd;
    logic [36:0] e;
    rdy  = mq.size() < DEPTH;
    take = mem_valid && rdy && (mem_rd != 0);
    byp  = 0;
`ifdef WB_BYPASS_EN
    byp = !alu_valid && (mq.size() == 0) && take;
`endif
    clr = 0;
    crd = 0;
    if (alu_valid && alu_rd != 0) begin
      m_we = 1; m_rd = alu_rd; m_data = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1; m_rd = e[36:32]; m_data = e[31:0];
      clr = 1; crd = m_rd;
    end else if (byp) begin
      m_we = 1; m_rd = mem_rd; m_data = mem_data;
      clr = 1; crd = mem_rd;
    end else begin
      m_we = 0;
    end
    if (take && !byp) mq.push_back({mem_rd, mem_data});
    if (clr) m_pend[crd] = 0;
    if (mem_issue && mem_issue_rd != 0) m_pend[mem_issue_rd] = 1;
  endtask

  initial begin
    tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 0, 0};
    tbl[1] = '{0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0};
    tbl[2] = '{1, 0, 32'h1111,     0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 0, 32'h2222,    0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 0, 0};
    tbl[4] = '{0, 0, 0,            0, 0, 0, 1, 9, 9, 0, 0, 5, 32'hDEADBEEF, 1, 1, 0};
    tbl[5] = '{1, 9, 32'h99,       0, 0, 0, 0, 0, 9, 0, 1, 9, 32'h99,       1, 1, 0};
    tbl[6] = '{0, 0, 0,            0, 0, 0, 1, 0, 0, 9, 0, 9, 32'h99,       1, 0, 1};
    tbl[7] = '{0, 0, 0,            0, 0, 0, 0, 0, 9, 0, 0, 9, 32'h99,       1, 1, 0};

    rst_n = 0;
    set_idle();
    #12;
    chk("reset_we", RegWrite, 0);
    chk("reset_rd", o_rd, 0);
    chk("reset_data", writeBackData, 0);
    chk("reset_busy", rs1_busy, 0);
    rst_n = 1;
    tick();
    chk("reset_ready", mem_ready, 1);

    for (int i = 0; i < 8; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
      mem_issue = tbl[i].mi; mem_issue_rd = tbl[i].mird;
      rs1 = tbl[i].r1; rs2 = tbl[i].r2;
      tick();
      chk($sformatf("tbl%0d_we", i), RegWrite, tbl[i].ewe);
      chk($sformatf("tbl%0d_rd", i), o_rd, tbl[i].erd);
      chk($sformatf("tbl%0d_data", i), writeBackData, tbl[i].ed);
      chk($sformatf("tbl%0d_ready", i), mem_ready, tbl[i].erdy);
      chk($sformatf("tbl%0d_b1", i), rs1_busy, tbl[i].eb1);
      chk($sformatf("tbl%0d_b2", i), rs2_busy, tbl[i].eb2);
    end

    // Memory latency plus scoreboard clear timing.
    do_reset();
    mem_issue = 1; mem_issue_rd = 7; rs1 = 7;
    tick();
    mem_issue = 0;
    chk("sb_set", rs1_busy, 1);
    mem_valid = 1; mem_rd = 7; mem_data = 32'h1234;
    tick();
    mem_valid = 0;
`ifndef WB_BYPASS_EN
    chk("lat_n1_we", RegWrite, 0);
    chk("lat_n1_busy", rs1_busy, 1);
    tick();
`endif
    chk("lat_we", RegWrite, 1);
    chk("lat_rd", o_rd, 7);
    chk("lat_data", writeBackData, 32'h1234);
    chk("sb_clear", rs1_busy, 0);
    tick();
    chk("lat_after_we", RegWrite, 0);

    // Fill FIFO while ALU holds priority, then drain in order.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      alu_valid = (c < 5); alu_rd = 5'(c + 1); alu_data = 32'(c);
      mem_valid = 1; mem_rd = 5'(10 + (c < 4 ? c : 4)); mem_data = 32'(100 + (c < 4 ? c : 4));
      #1;
      chk($sformatf("fill%0d_ready", c), mem_ready, (c < 4 || c == 6) ? 1 : 0);
      tick();
      if (c < 5) chk($sformatf("fill%0d_alu_rd", c), o_rd, 5'(c + 1));
      else       chk($sformatf("fill%0d_pop_rd", c), o_rd, 5'(5 + c));
    end
    set_idle();
    for (int c = 7; c < 10; c++) begin
      tick();
      chk($sformatf("drain%0d_we", c), RegWrite, 1);
      chk($sformatf("drain%0d_rd", c), o_rd, 5'(5 + c));
      chk($sformatf("drain%0d_data", c), writeBackData, 32'(95 + c));
    end
    tick();
    chk("drain_end_we", RegWrite, 0);

    // Asynchronous reset with entries queued and a pending bit set.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 32'hA0;
      mem_valid = 1; mem_rd = 5'(20 + c); mem_data = 32'(c);
      mem_issue = (c == 0); mem_issue_rd = 3; rs1 = 3;
      tick();
    end
    chk("pre_rst_busy", rs1_busy, 1);
    chk("pre_rst_we", RegWrite, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_we", RegWrite, 0);
    chk("arst_rd", o_rd, 0);
    chk("arst_data", writeBackData, 0);
    chk("arst_busy", rs1_busy, 0);
    set_idle();
    rs1 = 3;
    #3;
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_rst%0d_we", c), RegWrite, 0);
      chk($sformatf("post_rst%0d_busy", c), rs1_busy, 0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      alu_valid = ($urandom % 3) == 0;
      alu_rd = 5'($urandom % 4);
      alu_data = $urandom;
      mem_valid = ($urandom % 3) != 0;
      mem_rd = 5'($urandom % 8);
      mem_data = $urandom;
      mem_issue = $urandom % 2;
      mem_issue_rd = 5'($urandom % 8);
      rs1 = 5'($urandom % 8);
      rs2 = 5'($urandom % 8);
      @(negedge clk);
      chk("rnd_ready", mem_ready, (mq.size() < DEPTH) ? 1 : 0);
      chk("rnd_b1_pre", rs1_busy, m_pend[rs1]);
      chk("rnd_b2_pre", rs2_busy, m_pend[rs2]);
      model_step();
      tick();
      chk("rnd_we", RegWrite, m_we);
      chk("rnd_rd", o_rd, m_rd);
      chk("rnd_data", writeBackData, m_data);
      chk("rnd_b1", rs1_busy, m_pend[rs1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
